// File: rtl/pcie_turnoff_init.sv
// Initiator side of the PCIe turn-off handshake: drain, notify, wait for ack/timeout, power off.
// Optional macro PCIE_TURNOFF_ACK_FILTER_EN requires 4 consecutive low ack samples in WAIT_ACK.
module pcie_turnoff_init #(
  parameter int unsigned PEND_W     = 4,
  parameter int unsigned TMO_W      = 16,
  parameter int unsigned TMO_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwr_down_req_i,
  input  logic              pwr_up_req_i,
  input  logic              req_sent_i,
  input  logic              compl_rcv_i,
  input  logic              cfg_turnoff_ok_n_i,
  output logic              cfg_to_turnoff_n_o,
  output logic              req_block_o,
  output logic              pwr_off_o,
  output logic              busy_o,
  output logic              tmo_err_o,
  output logic [PEND_W-1:0] pend_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_NOTIFY, S_WAIT_ACK, S_OFF
  } state_e;

  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_e              state_q, state_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                err_q, err_d;
  logic                to_n_q, blk_q, off_q, busy_q;
  logic                ack_qual_c;

`ifdef PCIE_TURNOFF_ACK_FILTER_EN
  logic [1:0] filt_q, filt_d;

  // Count consecutive low ack samples; only counts inside WAIT_ACK
  always_comb begin
    filt_d = 2'd0;
    if (state_q == S_WAIT_ACK && !cfg_turnoff_ok_n_i) begin
      filt_d = (filt_q == 2'd3) ? filt_q : filt_q + 2'd1;
    end
  end

  assign ack_qual_c = !cfg_turnoff_ok_n_i && (filt_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) filt_q <= 2'd0;
    else     filt_q <= filt_d;
  end
`else
  assign ack_qual_c = !cfg_turnoff_ok_n_i;
`endif

  // Saturating outstanding-request counter, active in every state
  always_comb begin
    pend_d = pend_q;
    if (req_sent_i && !compl_rcv_i && pend_q != PEND_MAX) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (compl_rcv_i && !req_sent_i && pend_q != '0) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (pwr_down_req_i) begin
          state_d = S_DRAIN;
          err_d   = 1'b0;
          tmo_d   = '0;
        end
      end
      S_DRAIN: begin
        if (pwr_up_req_i) begin
          state_d = S_IDLE;
        end else if (pend_q == '0) begin
          state_d = S_NOTIFY;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_NOTIFY;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_NOTIFY: begin
        state_d = S_WAIT_ACK;
        tmo_d   = '0;
      end
      S_WAIT_ACK: begin
        if (pwr_up_req_i) begin
          state_d = S_IDLE;
        end else if (ack_qual_c) begin
          state_d = S_OFF;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_OFF;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_OFF: begin
        if (pwr_up_req_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, decoded from the next state so they track state_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      to_n_q  <= 1'b1;
      blk_q   <= 1'b0;
      off_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      to_n_q  <= !(state_d == S_NOTIFY || state_d == S_WAIT_ACK);
      blk_q   <= (state_d != S_IDLE);
      off_q   <= (state_d == S_OFF);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign cfg_to_turnoff_n_o = to_n_q;
  assign req_block_o        = blk_q;
  assign pwr_off_o          = off_q;
  assign busy_o             = busy_q;
  assign tmo_err_o          = err_q;
  assign pend_cnt_o         = pend_q;

endmodule

// File: tb/tb_pcie_turnoff_init.sv
// Scoreboard bench for pcie_turnoff_init (PEND_W=2, TMO_CYCLES=10).
module tb_pcie_turnoff_init;

  localparam int unsigned PW = 2;
  localparam int ID = 0, DR = 1, NO = 2, WA = 3, OF = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pd = 1'b0, pu = 1'b0, rs = 1'b0, cr = 1'b0, an = 1'b1;
  logic          to_n, blk, off, busy, err;
  logic [PW-1:0] pend;

  int total = 0;
  int bad   = 0;

  logic [6:0] exp_q[$];
  string      name_q[$];

  pcie_turnoff_init #(.PEND_W(PW), .TMO_W(16), .TMO_CYCLES(10)) dut (
    .clk(clk), .rst(rst),
    .pwr_down_req_i(pd), .pwr_up_req_i(pu), .req_sent_i(rs), .compl_rcv_i(cr),
    .cfg_turnoff_ok_n_i(an),
    .cfg_to_turnoff_n_o(to_n), .req_block_o(blk), .pwr_off_o(off),
    .busy_o(busy), .tmo_err_o(err), .pend_cnt_o(pend)
  );

  always #5 clk = ~clk;

  wire [6:0] act = {to_n, blk, off, busy, err, pend};

  // Expected {to_n, block, off, busy, err, pend} for a given state
  function automatic logic [6:0] vec(input int st, input logic e, input logic [1:0] p);
    logic [3:0] o;
    case (st)
      ID:      o = 4'b1000;
      DR:      o = 4'b1101;
      NO, WA:  o = 4'b0101;
      default: o = 4'b1111;
    endcase
    return {o, e, p};
  endfunction

  task automatic chk(input string nm, input logic [6:0] a, input logic [6:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b expected %b (to_n,blk,off,busy,err,pend)", nm, a, e);
    end
  endtask

  task automatic step(input logic d, input logic u, input logic s, input logic c, input logic k,
                      input int st, input logic e, input logic [1:0] p, input string nm);
    @(negedge clk);
    pd = d; pu = u; rs = s; cr = c; an = k;
    exp_q.push_back(vec(st, e, p));
    name_q.push_back(nm);
  endtask

  // Extra WAIT_ACK cycles needed when the ack filter is built in
  task automatic ack_extra(input logic e, input logic [1:0] p);
`ifdef PCIE_TURNOFF_ACK_FILTER_EN
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, WA, e, p, "ack_filter_wait");
`endif
  endtask

  initial begin : monitor
    logic [6:0] e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk(n, act, e);
      end
    end
  end

  initial begin : driver
    repeat (2) @(posedge clk);
    #1 chk("reset_state", act, vec(ID, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    // Normal sequence, pend 0, ack already low
    step(1, 0, 0, 0, 0, DR, 0, 0, "norm_drain_e1");
    step(0, 0, 0, 0, 0, NO, 0, 0, "norm_notify_e2");
    step(0, 0, 0, 0, 0, WA, 0, 0, "norm_wait_e3");
    ack_extra(0, 0);
    step(0, 0, 0, 0, 0, OF, 0, 0, "norm_off_e4");
    step(0, 0, 0, 0, 0, OF, 0, 0, "norm_off_hold");
    step(0, 1, 0, 0, 1, ID, 0, 0, "norm_powerup");

    // Drain with outstanding requests, then abort from WAIT_ACK
    step(0, 0, 1, 0, 1, ID, 0, 1, "pend_req1");
    step(0, 0, 1, 0, 1, ID, 0, 2, "pend_req2");
    step(0, 0, 1, 0, 1, ID, 0, 3, "pend_req3");
    step(1, 0, 0, 0, 1, DR, 0, 3, "drain_p3");
    step(0, 0, 0, 1, 1, DR, 0, 2, "drain_p2");
    step(0, 0, 1, 1, 1, DR, 0, 2, "drain_both");
    step(0, 0, 0, 1, 1, DR, 0, 1, "drain_p1");
    step(0, 0, 0, 1, 1, DR, 0, 0, "drain_p0");
    step(0, 0, 0, 0, 1, NO, 0, 0, "drain_notify");
    step(0, 0, 0, 0, 1, WA, 0, 0, "drain_wait");
    step(0, 1, 0, 0, 1, ID, 0, 0, "abort_wait");

    // Ack timeout: WAIT_ACK lasts exactly 10 cycles
    step(1, 0, 0, 0, 1, DR, 0, 0, "tmo_drain");
    step(0, 0, 0, 0, 1, NO, 0, 0, "tmo_notify");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, WA, 0, 0, "tmo_wait");
    step(0, 0, 0, 0, 1, OF, 1, 0, "tmo_off_err");
    step(1, 0, 0, 0, 1, OF, 1, 0, "off_ignores_down");
    step(0, 1, 0, 0, 1, ID, 1, 0, "err_sticky_idle");
    step(0, 0, 0, 1, 1, ID, 1, 0, "compl_at_zero");
    step(1, 0, 0, 0, 1, DR, 0, 0, "err_clear_drain");
    step(0, 1, 0, 0, 1, ID, 0, 0, "abort_drain");

    // Saturation at 2^PEND_W-1
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 0, 1, ID, 0, (i < 3) ? 2'(i + 1) : 2'd3, "pend_sat");
    step(0, 0, 0, 1, 1, ID, 0, 2, "pend_dec2");
    step(0, 0, 0, 1, 1, ID, 0, 1, "pend_dec1");

    // Drain timeout with one request never completing
    step(1, 0, 0, 0, 1, DR, 0, 1, "dtmo_drain");
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1, DR, 0, 1, "dtmo_hold");
    step(0, 0, 0, 0, 0, NO, 1, 1, "dtmo_notify_err");
    step(0, 0, 0, 0, 0, WA, 1, 1, "dtmo_wait");
    ack_extra(1, 1);
    step(0, 0, 0, 0, 0, OF, 1, 1, "dtmo_off");
    step(0, 1, 0, 0, 1, ID, 1, 1, "dtmo_powerup");

    // Asynchronous reset in the middle of DRAIN
    step(1, 0, 0, 0, 1, DR, 0, 1, "rst_drain");
    step(0, 0, 0, 0, 1, DR, 0, 1, "rst_drain2");
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_rst", act, vec(ID, 0, 0));
    @(negedge clk);
    rst = 1'b0;

`ifdef PCIE_TURNOFF_ACK_FILTER_EN
    step(1, 0, 0, 0, 1, DR, 0, 0, "filt_drain");
    step(0, 0, 0, 0, 1, NO, 0, 0, "filt_notify");
    step(0, 0, 0, 0, 1, WA, 0, 0, "filt_wait");
    step(0, 0, 0, 0, 0, WA, 0, 0, "filt_s0");
    step(0, 0, 0, 0, 0, WA, 0, 0, "filt_s1");
    step(0, 0, 0, 0, 1, WA, 0, 0, "filt_s2_high");
    step(0, 0, 0, 0, 0, WA, 0, 0, "filt_s3");
    step(0, 0, 0, 0, 0, WA, 0, 0, "filt_s4");
    step(0, 0, 0, 0, 0, WA, 0, 0, "filt_s5");
    step(0, 0, 0, 0, 0, OF, 0, 0, "filt_off");
    step(0, 1, 0, 0, 1, ID, 0, 0, "filt_powerup");
`endif

    @(negedge clk);
    pd = 0; pu = 0; rs = 0; cr = 0; an = 1;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
